// File: rtl/round_sat_stream.sv
// round_sat_stream: NUM_CH-lane streaming align/round/saturate with valid/ready backpressure.
// Define ROUND_SAT_STREAM_SATCNT_EN to add the saturation event counter (o_sat_cnt, i_sat_clr).
module round_sat_stream #(
  parameter int NUM_CH    = 4,
  parameter int WIDTH_IN  = 19,
  parameter int WIDTH_OUT = 16,
  parameter int IS_SIGNED = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [7:0]                  i_prec,
  input  logic [1:0]                  i_mode,
  input  logic [NUM_CH*WIDTH_IN-1:0]  i_data,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic [NUM_CH*WIDTH_OUT-1:0] o_data,
  output logic [NUM_CH-1:0]           o_sat
`ifdef ROUND_SAT_STREAM_SATCNT_EN
  ,
  input  logic                        i_sat_clr,
  output logic [15:0]                 o_sat_cnt
`endif
);

  localparam int         D            = WIDTH_IN - WIDTH_OUT;
  localparam int         SW           = WIDTH_OUT + 1;
  localparam bit         SIGNED_LANES = (IS_SIGNED != 0);
  localparam logic [7:0] WIN8         = 8'(WIDTH_IN);

  localparam logic [WIDTH_OUT-1:0] MAX_POS = {1'b0, {(WIDTH_OUT-1){1'b1}}};
  localparam logic [WIDTH_OUT-1:0] MIN_NEG = {1'b1, {(WIDTH_OUT-1){1'b0}}};

  logic                   s1_full;
  logic                   s2_load;
  logic                   s1_load;
  logic                   in_fire;
  logic                   s1_move;
  logic [7:0]             prec_eff;
  logic [7:0]             shamt;
  logic [NUM_CH*SW-1:0]   st1_sum_d;
  logic [NUM_CH-1:0]      st1_neg_d;
  logic [NUM_CH*SW-1:0]   s1_sum;
  logic [NUM_CH-1:0]      s1_neg;
  logic [NUM_CH*WIDTH_OUT-1:0] sat_data_d;
  logic [NUM_CH-1:0]      sat_flag_d;

  // Each stage loads when empty or when its current beat moves on this cycle.
  assign s2_load = !o_valid || i_ready;
  assign s1_load = !s1_full || s2_load;
  assign o_ready = s1_load;
  assign in_fire = i_valid && o_ready;
  assign s1_move = s1_full && s2_load;

  // NOTE: combinational blocks assign a default first so every path drives the output and no latch is inferred.
  always_comb begin
    prec_eff = i_prec;
    if (i_prec == 8'd0 || i_prec > WIN8) prec_eff = WIN8;
    shamt = WIN8 - prec_eff;
  end

  // Left shift discards bits above p-1, so the lane's sign bit lands on the MSB.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    logic [WIDTH_IN-1:0]  aligned;
    logic [WIDTH_OUT-1:0] t;
    logic                 neg;
    logic                 t_ext;
    logic                 r;

    assign aligned = i_data[k*WIDTH_IN +: WIDTH_IN] << shamt;
    assign t       = aligned[WIDTH_IN-1 -: WIDTH_OUT];
    assign neg     = SIGNED_LANES && aligned[WIDTH_IN-1];
    assign t_ext   = SIGNED_LANES && t[WIDTH_OUT-1];

    if (D > 0) begin : g_round
      logic [D-1:0] f;
      logic         half;
      logic         rest_zero;
      logic         above;
      logic         tie;

      assign f         = aligned[D-1:0];
      assign half      = f[D-1];
      assign rest_zero = ((f << 1) == '0);
      assign above     = half && !rest_zero;
      assign tie       = half && rest_zero;

      always_comb begin
        case (i_mode)
          2'd0:    r = 1'b0;
          2'd1:    r = half;
          2'd2:    r = above || (tie && !neg);
          default: r = above || (tie && t[0]);
        endcase
      end
    end else begin : g_pass
      assign r = 1'b0;
    end

    assign st1_sum_d[k*SW +: SW] = {t_ext, t} + SW'(r);
    assign st1_neg_d[k]          = neg;
  end

  // Stage-2 clamp: one guard bit above the rounded value detects overflow.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_sat
    logic [SW-1:0] s;
    logic          ovf;

    assign s = s1_sum[k*SW +: SW];

    if (SIGNED_LANES) begin : g_signed
      assign ovf = s[SW-1] ^ s[SW-2];
      assign sat_data_d[k*WIDTH_OUT +: WIDTH_OUT] =
        !ovf ? s[WIDTH_OUT-1:0] : (s1_neg[k] ? MIN_NEG : MAX_POS);
    end else begin : g_unsigned
      assign ovf = s[SW-1];
      assign sat_data_d[k*WIDTH_OUT +: WIDTH_OUT] = ovf ? '1 : s[WIDTH_OUT-1:0];
    end

    assign sat_flag_d[k] = ovf;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_full <= 1'b0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_sat   <= '0;
    end else begin
      if (s1_load) s1_full <= in_fire;
      if (s2_load) o_valid <= s1_full;
      if (s1_move) begin
        o_data <= sat_data_d;
        o_sat  <= sat_flag_d;
      end
    end
  end

  // NOTE: stage-1 payload has no reset; it is only observed while s1_full is set.
  always_ff @(posedge i_clk) begin
    if (in_fire) begin
      s1_sum <= st1_sum_d;
      s1_neg <= st1_neg_d;
    end
  end

`ifdef ROUND_SAT_STREAM_SATCNT_EN
  logic [15:0] sat_pop;
  logic [16:0] cnt_sum;

  always_comb begin
    sat_pop = '0;
    for (int k = 0; k < NUM_CH; k++) sat_pop = sat_pop + 16'(o_sat[k]);
    cnt_sum = {1'b0, o_sat_cnt} + {1'b0, sat_pop};
  end

  // Clear has priority over a same-cycle increment; the count sticks at 0xFFFF.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sat_cnt <= '0;
    end else if (i_sat_clr) begin
      o_sat_cnt <= '0;
    end else if (o_valid && i_ready) begin
      o_sat_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_round_sat_stream.sv
// Scoreboard bench for round_sat_stream: directed beats push expectations, a negedge monitor pops and compares.
module tb_round_sat_stream;

  localparam int LW = 4 * 19;
  localparam int OW = 4 * 16;

  typedef struct packed {
    logic [OW-1:0] d;
    logic [3:0]    s;
  } exp_t;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_valid;
  logic          o_ready;
  logic [7:0]    i_prec;
  logic [1:0]    i_mode;
  logic [LW-1:0] i_data;
  logic          o_valid;
  logic          i_ready;
  logic [OW-1:0] o_data;
  logic [3:0]    o_sat;
`ifdef ROUND_SAT_STREAM_SATCNT_EN
  logic          i_sat_clr;
  logic [15:0]   o_sat_cnt;
`endif

  exp_t          q[$];
  int            pass_cnt  = 0;
  int            total_cnt = 0;
  int            out_idx   = 0;
  logic          saw_stall = 1'b0;
  logic          stalled_prev = 1'b0;
  logic [OW-1:0] held_d;
  logic [3:0]    held_s;

  always #5 i_clk = ~i_clk;

  round_sat_stream dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_prec  (i_prec),
    .i_mode  (i_mode),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_sat   (o_sat)
`ifdef ROUND_SAT_STREAM_SATCNT_EN
    ,
    .i_sat_clr (i_sat_clr),
    .o_sat_cnt (o_sat_cnt)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [LW-1:0] pin(input logic [18:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [OW-1:0] pout(input logic [15:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send(input logic [7:0] prec, input logic [1:0] mode, input logic [LW-1:0] data,
                      input logic [OW-1:0] exp_d, input logic [3:0] exp_s);
    int waited = 0;
    exp_t e;
    i_valid = 1'b1;
    i_prec  = prec;
    i_mode  = mode;
    i_data  = data;
    @(negedge i_clk);
    while (!o_ready && waited < 20) begin
      saw_stall = 1'b1;
      waited++;
      @(negedge i_clk);
    end
    if (!o_ready) begin
      check("send_accept", {63'd0, o_ready}, 64'd1);
    end else begin
      e.d = exp_d;
      e.s = exp_s;
      q.push_back(e);
    end
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge i_clk);
      n++;
    end
    check("drain_empty", 64'(q.size()), 64'd0);
    @(posedge i_clk);
    #1;
  endtask

  always @(negedge i_clk) begin
    exp_t e;
    if (i_rst_n) begin
      if (stalled_prev) begin
        check("hold_data", o_data, held_d);
        check("hold_sat", {60'd0, o_sat}, {60'd0, held_s});
      end
      if (o_valid && !i_ready) begin
        stalled_prev = 1'b1;
        held_d = o_data;
        held_s = o_sat;
      end else begin
        stalled_prev = 1'b0;
      end
      if (o_valid && i_ready) begin
        if (q.size() == 0) begin
          check("unexpected_beat", {63'd0, o_valid}, 64'd0);
        end else begin
          e = q.pop_front();
          check($sformatf("beat%0d_data", out_idx), o_data, e.d);
          check($sformatf("beat%0d_sat", out_idx), {60'd0, o_sat}, {60'd0, e.s});
        end
        out_idx++;
      end
    end else begin
      stalled_prev = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   n;
    logic seen;
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_prec  = 8'd19;
    i_mode  = 2'd0;
    i_data  = '0;
    i_ready = 1'b1;
`ifdef ROUND_SAT_STREAM_SATCNT_EN
    i_sat_clr = 1'b0;
`endif
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_o_valid", {63'd0, o_valid}, 64'd0);
    check("rst_o_data", o_data, 64'd0);
    check("rst_o_sat", {60'd0, o_sat}, 64'd0);
    #3 i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    check("rst_o_ready", {63'd0, o_ready}, 64'd1);

    // Half-even ties and the two-cycle latency.
    send(8'd19, 2'd3, pin(19'd20, 19'd28, 19'd12, 19'd36), pout(16'd2, 16'd4, 16'd2, 16'd4), 4'b0000);
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!o_valid && n < 10);
    check("latency", 64'(n), 64'd2);
    drain();

    // Rounding modes on -3.5, 2.5, -2.5, 2.625.
    send(8'd19, 2'd0, pin(19'h7FFE4, 19'd20, 19'h7FFEC, 19'd21),
         pout(16'hFFFC, 16'd2, 16'hFFFD, 16'd2), 4'b0000);
    send(8'd19, 2'd1, pin(19'h7FFE4, 19'd20, 19'h7FFEC, 19'd21),
         pout(16'hFFFD, 16'd3, 16'hFFFE, 16'd3), 4'b0000);
    send(8'd19, 2'd2, pin(19'h7FFE4, 19'd20, 19'h7FFEC, 19'd21),
         pout(16'hFFFC, 16'd3, 16'hFFFD, 16'd3), 4'b0000);
    send(8'd19, 2'd3, pin(19'h7FFE4, 19'd20, 19'h7FFEC, 19'd21),
         pout(16'hFFFC, 16'd2, 16'hFFFE, 16'd3), 4'b0000);
    drain();

    // Saturation at the positive rail, and the exact negative rail without clamping.
    send(8'd19, 2'd1, pin(19'h3FFFF, 19'h40000, 19'h3FFFC, 19'd0),
         pout(16'h7FFF, 16'h8000, 16'h7FFF, 16'h0000), 4'b0101);
    send(8'd19, 2'd0, pin(19'h40000, 19'h3FFFF, 19'd0, 19'd0),
         pout(16'h8000, 16'h7FFF, 16'h0000, 16'h0000), 4'b0000);
    drain();

    // Precision handling: upper bits ignored, 0 and out-of-range clamp to WIDTH_IN.
    send(8'd16, 2'd3, pin(19'h0ABCD, 19'h7ABCD, 19'h00012, 19'h0FFFF),
         pout(16'hABCD, 16'hABCD, 16'h0012, 16'hFFFF), 4'b0000);
    send(8'd0, 2'd3, pin(19'd20, 19'd28, 19'h7FFE4, 19'd36),
         pout(16'd2, 16'd4, 16'hFFFC, 16'd4), 4'b0000);
    send(8'd200, 2'd3, pin(19'd20, 19'd28, 19'h7FFE4, 19'd36),
         pout(16'd2, 16'd4, 16'hFFFC, 16'd4), 4'b0000);
    send(8'd8, 2'd1, pin(19'h00080, 19'h0007F, 19'h001FF, 19'h00040),
         pout(16'h8000, 16'h7F00, 16'hFF00, 16'h4000), 4'b0000);
    drain();

    // Back-to-back stream with a three-cycle downstream stall.
    saw_stall = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          send(8'd19, 2'd0,
               pin(19'(i*64), 19'(i*64 + 8), 19'(i*64 + 16), 19'(i*64 + 24)),
               pout(16'(i*8), 16'(i*8 + 1), 16'(i*8 + 2), 16'(i*8 + 3)), 4'b0000);
        end
      end
      begin
        repeat (3) @(posedge i_clk);
        #1 i_ready = 1'b0;
        repeat (3) @(posedge i_clk);
        #1 i_ready = 1'b1;
      end
    join
    drain();
    check("stream_backpressure", {63'd0, saw_stall}, 64'd1);

    // Reset with two beats in flight.
    i_ready = 1'b0;
    send(8'd19, 2'd0, pin(19'd8, 19'd16, 19'd24, 19'd32), pout(16'd1, 16'd2, 16'd3, 16'd4), 4'b0000);
    send(8'd19, 2'd0, pin(19'd40, 19'd48, 19'd56, 19'd64), pout(16'd5, 16'd6, 16'd7, 16'd8), 4'b0000);
    #2;
    check("pre_rst_valid", {63'd0, o_valid}, 64'd1);
    i_rst_n = 1'b0;
    #1;
    check("midrst_o_valid", {63'd0, o_valid}, 64'd0);
    check("midrst_o_data", o_data, 64'd0);
    check("midrst_o_sat", {60'd0, o_sat}, 64'd0);
    q.delete();
    @(posedge i_clk);
    #3 i_rst_n = 1'b1;
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    check("postrst_o_ready", {63'd0, o_ready}, 64'd1);
    seen = 1'b0;
    repeat (6) begin
      @(negedge i_clk);
      if (o_valid) seen = 1'b1;
    end
    check("postrst_flushed", {63'd0, seen}, 64'd0);
    @(posedge i_clk);
    #1;
    send(8'd19, 2'd1, pin(19'd12, 19'd4, 19'd3, 19'h7FFFC), pout(16'd2, 16'd1, 16'd0, 16'h0000), 4'b0000);
    drain();

`ifdef ROUND_SAT_STREAM_SATCNT_EN
    check("cnt_start", {48'd0, o_sat_cnt}, 64'd0);
    repeat (3) begin
      send(8'd19, 2'd1, pin(19'h3FFFF, 19'h3FFFC, 19'd0, 19'd8),
           pout(16'h7FFF, 16'h7FFF, 16'h0000, 16'h0001), 4'b0011);
    end
    drain();
    check("cnt_after3", {48'd0, o_sat_cnt}, 64'd6);
    i_sat_clr = 1'b1;
    send(8'd19, 2'd1, pin(19'h3FFFF, 19'h3FFFC, 19'd0, 19'd8),
         pout(16'h7FFF, 16'h7FFF, 16'h0000, 16'h0001), 4'b0011);
    drain();
    i_sat_clr = 1'b0;
    @(negedge i_clk);
    check("cnt_clr_wins", {48'd0, o_sat_cnt}, 64'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/round_sat_stream.md
Name: round_sat_stream

Overview:
- Multi-channel streaming rounder/saturator. Successor to the single-channel fixed-latency rounder.
- Per beat, each of NUM_CH lanes is left-aligned from a runtime precision, rounded from WIDTH_IN to WIDTH_OUT bits in a runtime-selected mode, and saturated.
- Adds a valid/ready handshake with full backpressure and per-lane saturation flags.
- Sits between wide accumulators/filters and narrower downstream datapaths.

Parameters:
- NUM_CH, 4: number of parallel lanes.
- WIDTH_IN, 19: input lane width, >= WIDTH_OUT.
- WIDTH_OUT, 16: output lane width, >= 2.
- IS_SIGNED, 1: 1 = two's complement, 0 = unsigned.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  input beat valid.
- o_ready  out  1  block can accept a beat.
- i_prec  in  8  valid bit count of each input lane, sampled with the beat.
- i_mode  in  2  rounding mode, sampled with the beat.
- i_data  in  NUM_CH*WIDTH_IN  packed lanes; lane k is at [k*WIDTH_IN +: WIDTH_IN].
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream accepts the output beat.
- o_data  out  NUM_CH*WIDTH_OUT  packed rounded lanes.
- o_sat  out  NUM_CH  per-lane saturation occurred on this beat.

Behaviour:
- Reset (async assert, sync deassert): o_valid=0, o_data=0, o_sat=0, both pipeline stages empty, counters 0. o_ready=1 from the first cycle after reset.
- A beat transfers on input when i_valid & o_ready, and on output when o_valid & i_ready.
- Two-stage pipeline, latency 2 cycles from input acceptance to o_valid, one beat per cycle throughput.
- Stall rule per stage: a stage loads when it is empty or its contents move on this cycle. o_ready = !s1_full | (!s2_full | i_ready). No beat is dropped or duplicated; order is preserved.
- o_data and o_sat hold stable while o_valid=1 and i_ready=0.
- Precision clamp: i_prec = 0 or i_prec > WIDTH_IN is treated as WIDTH_IN.
- Stage 1, align: shift each lane left by WIDTH_IN - p.
  - Signed lanes: bit p-1 is the sign. Bits above p-1 are ignored, i.e. sign-extended from bit p-1 before the shift.
  - Unsigned lanes: bits above p-1 are ignored (zero-extended).
- Stage 1, split: D = WIDTH_IN - WIDTH_OUT. t = aligned[WIDTH_IN-1:D] (floor). f = aligned[D-1:0]. H = 1 << (D-1).
- Stage 1, round increment r (0 or 1):
  - mode 0 truncate: r = 0.
  - mode 1 half-up: r = (f >= H).
  - mode 2 half-away-from-zero: r = (f > H) | (f == H & !neg), where neg = IS_SIGNED & sign bit.
  - mode 3 half-even: r = (f > H) | (f == H & t[0]).
  - Compute s = t + r with one extra bit.
  - If D == 0: r = 0 and the lane passes through.
- Stage 2, saturate:
  - Signed overflow (s[MSB] != s[MSB-1]): clamp to 2^(WIDTH_OUT-1)-1, or to -2^(WIDTH_OUT-1) if the input was negative.
  - Unsigned carry-out: clamp to all-ones.
  - o_sat[k] = 1 exactly when lane k was clamped.
- i_mode and i_prec may change every beat. Each beat uses the values sampled with it.

Optional Feature:
- Macro ROUND_SAT_STREAM_SATCNT_EN.
- Defined: adds port o_sat_cnt, out, 16 bits, and port i_sat_clr, in, 1 bit.
  - o_sat_cnt increments by popcount(o_sat) on each output transfer and saturates at 0xFFFF.
  - i_sat_clr zeroes it synchronously. If a clear and an increment happen in the same cycle, the clear wins.
- Undefined: neither port exists and no counter logic is built.

Test Plan (defaults, signed, i_ready=1 unless stated):
- prec=19, mode=3, lanes = 20, 28, 12, 36 -> o_data lanes 2, 4, 2, 4 (2.5 to 2, 3.5 to 4, 1.5 to 2, 4.5 to 4). o_valid exactly 2 cycles after acceptance, o_sat=0.
- prec=19, lane = 0x7FFE4 (-28) under modes 0/1/2/3 -> 0xFFFC, 0xFFFD, 0xFFFC, 0xFFFC.
- prec=19, lane = 0x3FFFF under mode 1 -> 0x7FFF with o_sat=1. Lane = 0x40000 under mode 0 -> 0x8000 with o_sat=0.
- prec=16, lane = 0x0ABCD, mode 3 -> 0xABCD (upper bits ignored, exact pass-through). prec=0 behaves as prec=19.
- Stream 6 back-to-back beats with i_ready held low for 3 cycles mid-stream:
  - o_ready drops once both stages are full.
  - All 6 outputs arrive in order, with o_data stable while stalled.
- Assert i_rst_n low for 1 cycle with 2 beats in flight -> o_valid=0 immediately, the in-flight beats never appear, o_ready=1 the cycle after deassertion.
- With ROUND_SAT_STREAM_SATCNT_EN: 3 beats with 2 saturating lanes each -> o_sat_cnt=6. Assert i_sat_clr during a saturating beat -> o_sat_cnt=0.
